// File: rtl/stack_pkg.sv
// Shared types and defaults for the parametrised LIFO stack.
package stack_pkg;

  localparam int DEF_DATA_W = 11;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLEAR,
    OP_REPLACE,
    OP_PUSH,
    OP_POP,
    OP_PEEK
  } stack_op_e;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one async read port.
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with replace, peek, occupancy and sticky errors.
module param_stack
  import stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic              peek,
  input  logic [PTR_W-1:0]  peek_idx,
  input  logic [DATA_W-1:0] d_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  output logic              empty,
  output logic              full,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  stack_op_e         w_op;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_n;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_dout_n;
  logic [DATA_W-1:0] w_rdata;
  logic              r_dv;
  logic              w_dv_n;
  logic              r_ovf;
  logic              r_unf;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic              w_we;
  logic [PTR_W-1:0]  w_waddr;
  logic [PTR_W-1:0]  w_raddr;
  logic [PTR_W-1:0]  w_top;
  logic [PTR_W-1:0]  w_peek_addr;
  logic              w_empty;
  logic              w_full;
  logic              w_peek_ok;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_MAX);
  // Low bits wrap to DEPTH-1 when full, which is the true top slot.
  assign w_top       = r_count[PTR_W-1:0] - PTR_W'(1);
  assign w_peek_addr = w_top - peek_idx;
  assign w_peek_ok   = ({1'b0, peek_idx} < r_count);

  always_comb begin
    w_op = OP_NONE;
    priority case (1'b1)
      clear:         w_op = OP_CLEAR;
      (push && pop): w_op = OP_REPLACE;
      push:          w_op = OP_PUSH;
      pop:           w_op = OP_POP;
      peek:          w_op = OP_PEEK;
      default:       w_op = OP_NONE;
    endcase
  end

  always_comb begin
    w_count_n = r_count;
    w_dout_n  = r_dout;
    w_dv_n    = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    w_we      = 1'b0;
    w_waddr   = r_count[PTR_W-1:0];
    w_raddr   = w_top;
    unique case (w_op)
      OP_CLEAR: w_count_n = '0;
      OP_REPLACE: begin
        w_we = 1'b1;
        if (w_empty) begin
          w_count_n = CNT_ONE;
          w_unf_set = 1'b1;
        end else begin
          w_waddr  = w_top;
          w_dout_n = w_rdata;
          w_dv_n   = 1'b1;
        end
      end
      OP_PUSH: begin
        if (w_full) begin
          w_ovf_set = 1'b1;
        end else begin
          w_we      = 1'b1;
          w_count_n = r_count + CNT_ONE;
        end
      end
      OP_POP: begin
        if (w_empty) begin
          w_unf_set = 1'b1;
        end else begin
          w_dout_n  = w_rdata;
          w_dv_n    = 1'b1;
          w_count_n = r_count - CNT_ONE;
        end
      end
      OP_PEEK: begin
        w_raddr = w_peek_addr;
        if (w_peek_ok) begin
          w_dout_n = w_rdata;
          w_dv_n   = 1'b1;
        end else begin
          w_unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_n;
      r_dout  <= w_dout_n;
      r_dv    <= w_dv_n;
      // A new error event outranks err_clr.
      r_ovf   <= w_ovf_set | (r_ovf & ~err_clr);
      r_unf   <= w_unf_set | (r_unf & ~err_clr);
    end
  end

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (d_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign d_out     = r_dout;
  assign d_valid   = r_dv;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: vector table, directed corners, random vs queue model.
module tb_param_stack;

  localparam int DW  = 11;
  localparam int DEP = 32;
  localparam int PW  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          peek = 1'b0;
  logic [PW-1:0] peek_idx = '0;
  logic [DW-1:0] d_in = '0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] d_out;
  logic          d_valid;
  logic          empty;
  logic          full;
  logic [PW:0]   count;
  logic          overflow;
  logic          underflow;

  param_stack #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .peek      (peek),
    .peek_idx  (peek_idx),
    .d_in      (d_in),
    .err_clr   (err_clr),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: queue back is top of stack.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  bit m_dv = 0;
  bit m_ov = 0;
  bit m_un = 0;

  typedef struct {
    bit c; bit ps; bit pp; bit pk; int idx; int d; bit ec;
    int e_do; bit e_dv; int e_cnt; bit e_un;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit c, bit ps, bit pp, bit pk, int idx, int d, bit ec);
    m_dv = 0;
    if (ec) begin
      m_ov = 0;
      m_un = 0;
    end
    if (c) begin
      mq.delete();
    end else if (ps && pp) begin
      if (mq.size() == 0) begin
        mq.push_back(DW'(d));
        m_un = 1;
      end else begin
        m_dout = mq[mq.size()-1];
        mq[mq.size()-1] = DW'(d);
        m_dv = 1;
      end
    end else if (ps) begin
      if (mq.size() == DEP) m_ov = 1;
      else mq.push_back(DW'(d));
    end else if (pp) begin
      if (mq.size() == 0) m_un = 1;
      else begin
        m_dout = mq.pop_back();
        m_dv = 1;
      end
    end else if (pk) begin
      if (idx < mq.size()) begin
        m_dout = mq[mq.size()-1-idx];
        m_dv = 1;
      end else begin
        m_un = 1;
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_dout"}, 32'(d_out), 32'(m_dout));
    chk({tag, "_dvalid"}, 32'(d_valid), 32'(m_dv));
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, "_full"}, 32'(full), 32'(mq.size() == DEP));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ov));
    chk({tag, "_unf"}, 32'(underflow), 32'(m_un));
  endtask

  task automatic cyc(string tag, bit c, bit ps, bit pp, bit pk, int idx, int d, bit ec);
    clear = c; push = ps; pop = pp; peek = pk;
    peek_idx = PW'(idx); d_in = DW'(d); err_clr = ec;
    model_step(c, ps, pp, pk, idx, d, ec);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    clear = 0; push = 0; pop = 0; peek = 0; err_clr = 0;
  endtask

  initial begin
    // c ps pp pk idx d ec | dout dv cnt un
    tbl[0]  = '{0,1,0,0,0,'h00A,0, 'h000,0,1,0};
    tbl[1]  = '{0,1,0,0,0,'h00B,0, 'h000,0,2,0};
    tbl[2]  = '{0,1,0,0,0,'h00C,0, 'h000,0,3,0};
    tbl[3]  = '{0,0,0,1,0,'h000,0, 'h00C,1,3,0};
    tbl[4]  = '{0,0,0,1,1,'h000,0, 'h00B,1,3,0};
    tbl[5]  = '{0,0,0,1,2,'h000,0, 'h00A,1,3,0};
    tbl[6]  = '{0,0,0,1,3,'h000,0, 'h00A,0,3,1};
    tbl[7]  = '{0,0,1,0,0,'h000,0, 'h00C,1,2,1};
    tbl[8]  = '{0,1,1,0,0,'h7FF,0, 'h00B,1,2,1};
    tbl[9]  = '{0,0,1,0,0,'h000,0, 'h7FF,1,1,1};
    tbl[10] = '{0,0,0,0,0,'h000,1, 'h7FF,0,1,0};
    tbl[11] = '{0,1,0,1,0,'h123,0, 'h7FF,0,2,0};
    tbl[12] = '{0,0,1,0,0,'h000,0, 'h123,1,1,0};
    tbl[13] = '{0,0,1,0,0,'h000,0, 'h00A,1,0,0};
    tbl[14] = '{0,0,1,0,0,'h000,0, 'h00A,0,0,1};
    tbl[15] = '{0,1,1,0,0,'h055,0, 'h00A,0,1,1};
    tbl[16] = '{0,0,1,0,0,'h000,0, 'h055,1,0,1};

    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc("tbl", tbl[i].c, tbl[i].ps, tbl[i].pp, tbl[i].pk,
          tbl[i].idx, tbl[i].d, tbl[i].ec);
      chk($sformatf("tbl%0d_dout", i), 32'(d_out), 32'(tbl[i].e_do));
      chk($sformatf("tbl%0d_dvalid", i), 32'(d_valid), 32'(tbl[i].e_dv));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_unf", i), 32'(underflow), 32'(tbl[i].e_un));
    end

    cyc("eclr", 0, 0, 0, 0, 0, 0, 1);

    for (int i = 1; i <= DEP; i++) cyc("fill", 0, 1, 0, 0, 0, i, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'(DEP));
    cyc("ovf", 0, 1, 0, 0, 0, 'h3FF, 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'(DEP));
    for (int i = 0; i < DEP; i++) begin
      cyc("drain", 0, 0, 1, 0, 0, 0, 0);
      chk($sformatf("drain%0d_dout", i), 32'(d_out), 32'(DEP - i));
      chk($sformatf("drain%0d_dv", i), 32'(d_valid), 32'd1);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    cyc("unf", 0, 0, 1, 0, 0, 0, 0);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_dv", 32'(d_valid), 32'd0);
    chk("unf_dout", 32'(d_out), 32'd1);

    cyc("clrseq", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("clrseq", 0, 1, 0, 0, 0, 'h100 + i, 0);
    cyc("clrpush", 1, 1, 0, 0, 0, 'h2AA, 0);
    chk("clrpush_count", 32'(count), 32'd0);
    cyc("clrseq", 0, 1, 0, 0, 0, 'h055, 0);
    cyc("clrseq", 0, 0, 1, 0, 0, 0, 0);
    chk("clrpop_dout", 32'(d_out), 32'h055);

    for (int n = 0; n < 3000; n++) begin
      int pp_pct;
      pp_pct = (n < 1500) ? 35 : 60;
      cyc("rnd",
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 55,
          $urandom_range(0, 99) < pp_pct,
          $urandom_range(0, 99) < 40,
          int'($urandom_range(0, DEP - 1)),
          int'($urandom_range(0, 2047)),
          $urandom_range(0, 99) < 5);
    end

    cyc("arst", 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc("arst", 0, 1, 0, 0, 0, 'h40 + i, 0);
    cyc("arst", 0, 0, 0, 1, 31, 0, 0);
    cyc("arst", 0, 0, 1, 0, 0, 0, 0);
    chk("arst_pre_count", 32'(count), 32'd5);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_dout = '0; m_dv = 0; m_ov = 0; m_un = 0;
    check_all("arst_now");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("arst_eclr", 0, 0, 1, 0, 0, 0, 1);
    chk("arst_eclr_unf", 32'(underflow), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack for the recursive-function datapaths: holds return addresses and arguments across recursive calls.
- Generalises the fixed 11-bit x 32-entry stack:
  - configurable width and depth;
  - explicit reset;
  - full flag and occupancy count;
  - sticky overflow/underflow errors;
  - registered read-valid strobe;
  - atomic replace (push+pop);
  - indexed peek below the top of stack, for frame access.

Parameters:
- DATA_W, 11, data word width in bits.
- DEPTH, 32, number of entries; must be a power of two, >= 2.
- PTR_W, $clog2(DEPTH), derived; width of the pointer and of peek_idx.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: count to 0; memory contents don't-care.
- push  in  1  write d_in on top.
- pop  in  1  read the top and remove it.
- peek  in  1  read the entry peek_idx below the top, without removal.
- peek_idx  in  PTR_W  0 = top of stack, 1 = next below, and so on.
- d_in  in  DATA_W  push data.
- err_clr  in  1  clears the sticky error flags.
- d_out  out  DATA_W  registered read data.
- d_valid  out  1  one-cycle strobe; d_out was updated this cycle.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  PTR_W+1  occupancy, range 0..DEPTH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop or peek was attempted with no valid entry.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = 0, d_out = 0, d_valid = 0, overflow = 0, underflow = 0.
  - The memory array is not reset.
- One operation per cycle. Priority: clear > push&pop (replace) > push > pop > peek.
- clear:
  - count <= 0, d_valid <= 0.
  - d_out holds its value.
  - Error flags are unaffected.
- push, not full:
  - mem[count] <= d_in, count <= count+1, d_valid <= 0.
- push, full:
  - No write; count is unchanged.
  - overflow <= 1.
- pop, count > 0:
  - d_out <= mem[count-1], count <= count-1, d_valid <= 1.
  - Latency is 1 cycle: data appears at the edge that retires the pop.
- pop, empty:
  - count is unchanged; d_out holds.
  - d_valid <= 0, underflow <= 1.
- peek, peek_idx < count:
  - d_out <= mem[count-1-peek_idx], d_valid <= 1.
  - count is unchanged.
- peek, peek_idx >= count:
  - d_out holds, d_valid <= 0, underflow <= 1.
- push&pop, count > 0 (replace):
  - d_out <= old mem[count-1], then mem[count-1] <= d_in.
  - count is unchanged, d_valid <= 1.
  - Read-before-write within the same edge.
  - This case is legal when full; overflow is not set.
- push&pop, empty:
  - Behaves as a plain push: write, count becomes 1.
  - d_valid <= 0, underflow <= 1.
- d_valid is deasserted in every cycle that did not perform a successful read.
- err_clr:
  - Clears both sticky flags.
  - If an error event occurs in the same cycle, the event wins and the flag is set.
- Count arithmetic is PTR_W+1 bits wide and never wraps. A failed op leaves count untouched.
- empty and full are combinational decodes of the count register.
- Simultaneous peek with push or pop: peek is ignored, per the priority order.

Decomposition:
- Package stack_pkg holds:
  - localparams DEF_DATA_W = 11, DEF_DEPTH = 32;
  - a typedef enum stack_op_e {OP_NONE, OP_CLEAR, OP_REPLACE, OP_PUSH, OP_POP, OP_PEEK}.
- The op encoding is produced by one combinational priority decode in the top level.
- One sub-module, stack_mem:
  - DEPTH x DATA_W storage;
  - one synchronous write port;
  - one asynchronous read port, addressed by the top level.
  - It owns no control state.

Test Plan:
- Reset, then push 1..32 (DEPTH = 32) → full = 1, count = 32. A 33rd push sets overflow = 1, and count stays 32.
- Pop 32 times → d_out = 32, 31, ..., 1 on consecutive cycles, d_valid = 1 each cycle, then empty = 1. A further pop sets underflow = 1, d_valid = 0, and d_out stays 1.
- Push 0x0A, 0x0B, 0x0C, then peek idx 0, 1, 2 → d_out = 0x0C, 0x0B, 0x0A; count stays 3. Peek idx 3 → underflow = 1.
- With stack [0x0A, 0x0B], drive push&pop with d_in = 0x7FF → d_out = 0x0B, count = 2. The next pop returns 0x7FF.
- Assert rst_n low mid-push sequence (count = 5) → count, flags and d_valid are 0 immediately, without waiting for a clock edge. Then apply err_clr together with a failing pop → underflow remains 1.
- Push 3 values, then clear together with push → count = 0, no write. Then push 0x055 and pop → d_out = 0x055.
